// File: rtl/hack_cpu_seq_if.sv
// Hack CPU sequencer bus: instruction fetch, data memory, ALU drive/result and debug taps.
`timescale 1ns/1ps
interface hack_cpu_seq_if #(
  parameter int PC_W    = 15,
  parameter int DADDR_W = 15
);
  logic               imem_req;
  logic [PC_W-1:0]    imem_addr;
  logic               imem_ack;
  logic [15:0]        imem_rdata;

  logic               dmem_req;
  logic               dmem_we;
  logic [DADDR_W-1:0] dmem_addr;
  logic [15:0]        dmem_wdata;
  logic               dmem_ack;
  logic [15:0]        dmem_rdata;

  logic [15:0]        alu_x;
  logic [15:0]        alu_y;
  logic               alu_zx;
  logic               alu_nx;
  logic               alu_zy;
  logic               alu_ny;
  logic               alu_f;
  logic               alu_no;
  logic [15:0]        alu_out;
  logic               alu_zr;
  logic               alu_ng;

  logic [PC_W-1:0]    pc;
  logic [15:0]        a_reg;
  logic [15:0]        d_reg;

  modport master (
    output imem_req, imem_addr,
    input  imem_ack, imem_rdata,
    output dmem_req, dmem_we, dmem_addr, dmem_wdata,
    input  dmem_ack, dmem_rdata,
    output alu_x, alu_y, alu_zx, alu_nx, alu_zy, alu_ny, alu_f, alu_no,
    input  alu_out, alu_zr, alu_ng,
    output pc, a_reg, d_reg
  );

  modport slave (
    input  imem_req, imem_addr,
    output imem_ack, imem_rdata,
    input  dmem_req, dmem_we, dmem_addr, dmem_wdata,
    output dmem_ack, dmem_rdata,
    input  alu_x, alu_y, alu_zx, alu_nx, alu_zy, alu_ny, alu_f, alu_no,
    output alu_out, alu_zr, alu_ng,
    input  pc, a_reg, d_reg
  );
endinterface

// File: rtl/hack_cpu_seq.sv
// Multi-cycle Hack CPU sequencer: A-instr 2 cycles, C-instr 4 (+1 M read, +1 M write) with 0-wait memories.
// Requests hold until ack; each memory wait state stretches the current state by one cycle.
`timescale 1ns/1ps
module hack_cpu_seq #(
  parameter int PC_W    = 15,
  parameter int DADDR_W = 15
) (
  input  logic          clk,
  input  logic          rst,
  hack_cpu_seq_if.master bus
);

  typedef enum logic [2:0] {
    S_FETCH,
    S_DECODE,
    S_MEMRD,
    S_EXEC,
    S_MEMWR,
    S_WB
  } state_t;

  state_t          state_q;
  logic [PC_W-1:0] pc_q;
  logic [15:0]     a_q;
  logic [15:0]     d_q;
  logic [15:0]     m_q;
  logic [15:0]     instr_q;
  logic [15:0]     res_q;
  logic            zr_q;
  logic            ng_q;
  logic            dmem_req_q;
  logic            dmem_we_q;

  logic [PC_W-1:0] pc_inc_d;
  logic [PC_W-1:0] pc_wb_d;
  logic            jump_taken_d;

  assign pc_inc_d     = pc_q + PC_W'(1);
  assign jump_taken_d = (instr_q[2] & ng_q)
                      | (instr_q[1] & zr_q)
                      | (instr_q[0] & ~zr_q & ~ng_q);
  // a_q still holds the pre-instruction A here, which is the Hack jump target.
  assign pc_wb_d      = jump_taken_d ? a_q[PC_W-1:0] : pc_inc_d;

  // Fetch request is a state decode; rst gates it so the very first cycle after release can fetch.
  assign bus.imem_req   = (state_q == S_FETCH) && !rst;
  assign bus.imem_addr  = pc_q;

  assign bus.dmem_req   = dmem_req_q;
  assign bus.dmem_we    = dmem_we_q;
  assign bus.dmem_addr  = a_q[DADDR_W-1:0];
  assign bus.dmem_wdata = res_q;

  assign bus.alu_x  = d_q;
  assign bus.alu_y  = instr_q[12] ? m_q : a_q;
  assign {bus.alu_zx, bus.alu_nx, bus.alu_zy, bus.alu_ny, bus.alu_f, bus.alu_no} = instr_q[11:6];

  assign bus.pc    = pc_q;
  assign bus.a_reg = a_q;
  assign bus.d_reg = d_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_FETCH;
      pc_q       <= '0;
      a_q        <= '0;
      d_q        <= '0;
      m_q        <= '0;
      instr_q    <= '0;
      res_q      <= '0;
      zr_q       <= 1'b0;
      ng_q       <= 1'b0;
      dmem_req_q <= 1'b0;
      dmem_we_q  <= 1'b0;
    end else begin
      case (state_q)
        S_FETCH: begin
          if (bus.imem_ack) begin
            instr_q <= bus.imem_rdata;
            state_q <= S_DECODE;
          end
        end

        S_DECODE: begin
          if (!instr_q[15]) begin
            a_q     <= instr_q;
            pc_q    <= pc_inc_d;
            state_q <= S_FETCH;
          end else if (instr_q[12]) begin
            dmem_req_q <= 1'b1;
            dmem_we_q  <= 1'b0;
            state_q    <= S_MEMRD;
          end else begin
            state_q <= S_EXEC;
          end
        end

        S_MEMRD: begin
          if (dmem_req_q && bus.dmem_ack) begin
            m_q        <= bus.dmem_rdata;
            dmem_req_q <= 1'b0;
            state_q    <= S_EXEC;
          end
        end

        S_EXEC: begin
          res_q <= bus.alu_out;
          zr_q  <= bus.alu_zr;
          ng_q  <= bus.alu_ng;
          if (instr_q[3]) begin
            dmem_req_q <= 1'b1;
            dmem_we_q  <= 1'b1;
            state_q    <= S_MEMWR;
          end else begin
            state_q <= S_WB;
          end
        end

        S_MEMWR: begin
          if (dmem_req_q && bus.dmem_ack) begin
            dmem_req_q <= 1'b0;
            dmem_we_q  <= 1'b0;
            state_q    <= S_WB;
          end
        end

        S_WB: begin
          if (instr_q[5]) a_q <= res_q;
          if (instr_q[4]) d_q <= res_q;
          pc_q    <= pc_wb_d;
          state_q <= S_FETCH;
        end

        default: begin
          dmem_req_q <= 1'b0;
          dmem_we_q  <= 1'b0;
          state_q    <= S_FETCH;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_hack_cpu_seq.sv
// Directed bench for hack_cpu_seq with behavioural memories and a Hack ALU model.
`timescale 1ns/1ps
module tb_hack_cpu_seq;

  logic clk;
  logic rst;

  hack_cpu_seq_if #(.PC_W(15), .DADDR_W(15)) bus ();

  hack_cpu_seq #(.PC_W(15), .DADDR_W(15)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [15:0] imem [0:32767];
  logic [15:0] dmem [0:32767];

  int   vectors;
  int   miscompares;
  int   dwait;
  int   dcnt;
  logic hold;
  logic late_ack;
  int   imem_cnt;
  int   dmem_cnt;
  int   overlap_cnt;
  int   wr_cnt;
  logic [15:0] last_waddr;
  logic [15:0] last_wdata;
  int   dmem_prev;

  function automatic logic [17:0] alu_model(input logic [15:0] x, input logic [15:0] y,
                                            input logic [5:0] c);
    logic [15:0] xa;
    logic [15:0] ya;
    logic [15:0] o;
    xa = c[5] ? 16'h0000 : x;
    xa = c[4] ? ~xa : xa;
    ya = c[3] ? 16'h0000 : y;
    ya = c[2] ? ~ya : ya;
    o  = c[1] ? (xa + ya) : (xa & ya);
    o  = c[0] ? ~o : o;
    return {(o == 16'h0000), o[15], o};
  endfunction

  assign {bus.alu_zr, bus.alu_ng, bus.alu_out} =
      alu_model(bus.alu_x, bus.alu_y,
                {bus.alu_zx, bus.alu_nx, bus.alu_zy, bus.alu_ny, bus.alu_f, bus.alu_no});

  assign bus.imem_ack   = bus.imem_req;
  assign bus.imem_rdata = imem[bus.imem_addr];
  assign bus.dmem_rdata = dmem[bus.dmem_addr];
  assign bus.dmem_ack   = late_ack | (bus.dmem_req && !hold && (dcnt >= dwait));

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      dcnt <= 0;
    end else if (bus.dmem_req && !bus.dmem_ack) begin
      dcnt <= dcnt + 1;
    end else begin
      dcnt <= 0;
    end
  end

  always @(posedge clk) begin
    if (!rst && bus.dmem_req && bus.dmem_ack && bus.dmem_we) begin
      dmem[bus.dmem_addr] <= bus.dmem_wdata;
      wr_cnt     <= wr_cnt + 1;
      last_waddr <= 16'(bus.dmem_addr);
      last_wdata <= bus.dmem_wdata;
    end
  end

  always @(negedge clk) begin
    if (!rst) begin
      imem_cnt <= imem_cnt + int'(bus.imem_req);
      dmem_cnt <= dmem_cnt + int'(bus.dmem_req);
      if (bus.imem_req && bus.dmem_req) overlap_cnt <= overlap_cnt + 1;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    dwait       = 0;
    hold        = 1'b0;
    late_ack    = 1'b0;
    imem_cnt    = 0;
    dmem_cnt    = 0;
    overlap_cnt = 0;
    wr_cnt      = 0;
    last_waddr  = '0;
    last_wdata  = '0;
    for (int i = 0; i < 32768; i++) begin
      imem[i] = 16'h0000;
      dmem[i] = 16'h0000;
    end
    imem[0]  = 16'h0015;  // @21
    imem[1]  = 16'hEC10;  // D=A
    imem[2]  = 16'h0064;  // @100
    imem[3]  = 16'hE7C8;  // M=D+1
    imem[4]  = 16'h0005;  // @5
    imem[5]  = 16'hFC10;  // D=M
    imem[6]  = 16'h000A;  // @10
    imem[7]  = 16'hE304;  // D;JLT
    imem[10] = 16'hE301;  // D;JGT
    imem[11] = 16'hEA90;  // D=0
    imem[12] = 16'h000E;  // @14
    imem[13] = 16'hEA87;  // 0;JMP
    imem[14] = 16'h00C8;  // @200
    imem[15] = 16'hE7E8;  // AM=D+1
    imem[16] = 16'h012C;  // @300
    imem[17] = 16'hE7C8;  // M=D+1
    imem[32767] = 16'h0007;  // @7
    dmem[5]  = 16'h8000;

    rst = 1'b0;
    #1 rst = 1'b1;
    #2;
    check("rst_pc",       32'(bus.pc), 32'h0);
    check("rst_a",        32'(bus.a_reg), 32'h0);
    check("rst_d",        32'(bus.d_reg), 32'h0);
    check("rst_imem_req", 32'(bus.imem_req), 32'h0);
    check("rst_dmem_req", 32'(bus.dmem_req), 32'h0);
    check("rst_dmem_we",  32'(bus.dmem_we), 32'h0);
    #5 rst = 1'b0;

    // @21 ; D=A
    step(6);
    check("t1_d",        32'(bus.d_reg), 32'd21);
    check("t1_a",        32'(bus.a_reg), 32'd21);
    check("t1_pc",       32'(bus.pc), 32'd2);
    check("t1_fetch_cy", 32'(imem_cnt), 32'd2);

    // @100 ; M=D+1
    step(7);
    check("t2_pc",      32'(bus.pc), 32'd4);
    check("t2_d",       32'(bus.d_reg), 32'd21);
    check("t2_wr_cnt",  32'(wr_cnt), 32'd1);
    check("t2_waddr",   32'(last_waddr), 32'd100);
    check("t2_wdata",   32'(last_wdata), 32'd22);
    check("t2_dmem100", 32'(dmem[100]), 32'd22);
    check("t2_dreq_cy", 32'(dmem_cnt), 32'd1);

    // @5 ; D=M with three read wait states
    dmem_prev = dmem_cnt;
    dwait = 3;
    step(9);
    check("t3_pc_early", 32'(bus.pc), 32'd5);
    step(1);
    check("t3_pc",      32'(bus.pc), 32'd6);
    check("t3_d",       32'(bus.d_reg), 32'h8000);
    check("t3_a",       32'(bus.a_reg), 32'd5);
    check("t3_dreq_cy", 32'(dmem_cnt - dmem_prev), 32'd4);
    dwait = 0;

    // @10 ; D;JLT taken, then D;JGT not taken
    step(6);
    check("t4_jlt_pc", 32'(bus.pc), 32'd10);
    step(4);
    check("t4_jgt_pc", 32'(bus.pc), 32'd11);
    step(4);
    check("t4_d_zero", 32'(bus.d_reg), 32'h0);
    check("t4_d0_pc",  32'(bus.pc), 32'd12);
    step(6);
    check("t4_jmp_pc", 32'(bus.pc), 32'd14);

    // @200 ; AM=D+1 writes M at old A, then A=1
    step(7);
    check("am_waddr", 32'(last_waddr), 32'd200);
    check("am_wdata", 32'(last_wdata), 32'd1);
    check("am_a",     32'(bus.a_reg), 32'd1);
    check("am_pc",    32'(bus.pc), 32'd16);
    check("am_wrcnt", 32'(wr_cnt), 32'd2);

    // @300 ; M=D+1 with ack withheld, reset during the write
    hold = 1'b1;
    step(7);
    check("t5_dreq_held", 32'(bus.dmem_req), 32'h1);
    check("t5_we",        32'(bus.dmem_we), 32'h1);
    check("t5_addr",      32'(bus.dmem_addr), 32'd300);
    check("t5_wdata",     32'(bus.dmem_wdata), 32'd1);
    check("t5_no_ireq",   32'(bus.imem_req), 32'h0);
    rst = 1'b1;
    #1;
    check("t5_rst_dreq", 32'(bus.dmem_req), 32'h0);
    check("t5_rst_ireq", 32'(bus.imem_req), 32'h0);
    check("t5_rst_pc",   32'(bus.pc), 32'h0);
    check("t5_rst_d",    32'(bus.d_reg), 32'h0);
    imem[0]  = 16'h7FFF;  // @32767
    imem[1]  = 16'hEA87;  // 0;JMP
    late_ack = 1'b1;
    hold     = 1'b0;
    #1 rst = 1'b0;
    #1;
    check("t5_first_ireq", 32'(bus.imem_req), 32'h1);
    check("t5_first_addr", 32'(bus.imem_addr), 32'h0);
    check("t5_late_dreq",  32'(bus.dmem_req), 32'h0);
    step(2);
    check("t5_late_pc",    32'(bus.pc), 32'd1);
    check("t5_late_a",     32'(bus.a_reg), 32'h7FFF);
    check("t5_late_wrcnt", 32'(wr_cnt), 32'd2);
    late_ack = 1'b0;

    // Jump to 0x7FFF, fetch an A-instruction there, PC wraps
    step(4);
    check("t6_pc_top", 32'(bus.pc), 32'h7FFF);
    step(2);
    check("t6_wrap_pc",   32'(bus.pc), 32'h0);
    check("t6_wrap_a",    32'(bus.a_reg), 32'd7);
    check("t6_wrap_addr", 32'(bus.imem_addr), 32'h0);

    check("no_req_overlap", 32'(overlap_cnt), 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
